oqpsk_tx_scheduler: RTL and testbench

OQPSK_TX_SCHEDULER -- requirements
Module: oqpsk_tx_scheduler

---
 rtl/oqpsk_tx_scheduler_pkg.sv | 18 +
 rtl/oqpsk_dual_read_buffer.sv | 58 +++++
 rtl/oqpsk_tx_scheduler.sv | 146 ++++++++++++++
 tb/tb_oqpsk_tx_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oqpsk_tx_scheduler_pkg.sv
// Shared typedefs for the OQPSK transmit path: component FSM states and scheduler states.
package oqpsk_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_SYMBOL = 2'd1,
        TX_DONE   = 2'd2
    } transmission_state_t;

    typedef enum logic [2:0] {
        SCH_IDLE     = 3'd0,
        SCH_PRIME    = 3'd1,
        SCH_START    = 3'd2,
        SCH_RUN      = 3'd3,
        SCH_WAIT_EOT = 3'd4
    } sched_state_t;

endpackage

// File: rtl/oqpsk_dual_read_buffer.sv
// Circular word buffer with one writer and two independent readers (I and Q paths).
// Latency: head visible the cycle after push; backpressure via full (lagging reader at DEPTH).
module oqpsk_dual_read_buffer #(
    parameter int DW    = 17,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_i,
    input  logic          pop_q,
    output logic [DW-1:0] head_i,
    output logic [DW-1:0] head_q,
    output logic [CW-1:0] occ_i,
    output logic [CW-1:0] occ_q,
    output logic          full
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_i;
    logic [PW-1:0] rd_ptr_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Each reader keeps its own occupancy; a slot is reusable only once the slower reader has passed it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr_i <= '0;
            rd_ptr_q <= '0;
            occ_i    <= '0;
            occ_q    <= '0;
        end else begin
            if (push)  wr_ptr   <= wrap_inc(wr_ptr);
            if (pop_i) rd_ptr_i <= wrap_inc(rd_ptr_i);
            if (pop_q) rd_ptr_q <= wrap_inc(rd_ptr_q);
            occ_i <= occ_i + CW'(push) - CW'(pop_i);
            occ_q <= occ_q + CW'(push) - CW'(pop_q);
        end
    end

    assign head_i = mem[rd_ptr_i];
    assign head_q = mem[rd_ptr_q];
    assign full   = (occ_i == CW'(DEPTH)) || (occ_q == CW'(DEPTH));

endmodule

// File: rtl/oqpsk_tx_scheduler.sv
// Splits AXIS words into I/Q bit packets and hands them to the two component FSMs on request.
// Packets update one cycle after a request; tready drops when the lagging path has the buffer full.
module oqpsk_tx_scheduler
    import oqpsk_tx_scheduler_pkg::*;
#(
    parameter int SAMPLES_PER_SYMBOL     = 4,
    parameter int C_S00_AXIS_TDATA_WIDTH = 16,
    parameter int BURST_SIZE             = 2,
    localparam int W  = C_S00_AXIS_TDATA_WIDTH,
    localparam int H  = W / 2,
    localparam int CW = $clog2(BURST_SIZE + 1)
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [W-1:0] s00_axis_tdata,
    input  logic         s00_axis_tvalid,
    output logic         s00_axis_tready,
    input  logic         s00_axis_tlast,
    input  logic         inphase_receive_data,
    input  logic         quadrature_receive_data,
    input  logic         end_of_transmission,
    output logic         start_fsms,
    output logic [H-1:0] inphase_packet,
    output logic [H-1:0] quadrature_packet,
    output logic         last_inphase_packet,
    output logic         last_quadrature_packet,
    output logic         busy,
    output logic         underrun
);

    if (SAMPLES_PER_SYMBOL < 1) begin : g_bad_sps
        $error("SAMPLES_PER_SYMBOL must be >= 1");
    end
    if (W < 4 || (W % 2) != 0) begin : g_bad_width
        $error("C_S00_AXIS_TDATA_WIDTH must be even and >= 4");
    end
    if (BURST_SIZE < 1) begin : g_bad_burst
        $error("BURST_SIZE must be >= 1");
    end

    sched_state_t  state;
    logic          tlast_accepted;
    logic          push;
    logic          pop_i;
    logic          pop_q;
    logic [W:0]    head_i;
    logic [W:0]    head_q;
    logic [CW-1:0] occ_i;
    logic [CW-1:0] occ_q;
    logic          full;

    function automatic logic [H-1:0] even_bits(input logic [W-1:0] d);
        logic [H-1:0] r;
        for (int k = 0; k < H; k++) r[k] = d[2*k];
        return r;
    endfunction

    function automatic logic [H-1:0] odd_bits(input logic [W-1:0] d);
        logic [H-1:0] r;
        for (int k = 0; k < H; k++) r[k] = d[2*k+1];
        return r;
    endfunction

    assign s00_axis_tready = !full && !tlast_accepted &&
                             ((state == SCH_PRIME) || (state == SCH_RUN));
    assign push  = s00_axis_tvalid && s00_axis_tready;
    assign busy  = (state != SCH_IDLE);
    // Requests after the path's final packet are dropped without touching the buffer.
    assign pop_i = (state == SCH_START) ||
                   ((state == SCH_RUN) && inphase_receive_data && !last_inphase_packet && (occ_i != '0));
    assign pop_q = (state == SCH_START) ||
                   ((state == SCH_RUN) && quadrature_receive_data && !last_quadrature_packet && (occ_q != '0));

    oqpsk_dual_read_buffer #(
        .DW    (W + 1),
        .DEPTH (BURST_SIZE)
    ) u_buf (
        .aclk     (aclk),
        .areset   (areset),
        .push     (push),
        .push_dat ({s00_axis_tlast, s00_axis_tdata}),
        .pop_i    (pop_i),
        .pop_q    (pop_q),
        .head_i   (head_i),
        .head_q   (head_q),
        .occ_i    (occ_i),
        .occ_q    (occ_q),
        .full     (full)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state                  <= SCH_IDLE;
            tlast_accepted         <= 1'b0;
            underrun               <= 1'b0;
            start_fsms             <= 1'b0;
            inphase_packet         <= '0;
            quadrature_packet      <= '0;
            last_inphase_packet    <= 1'b0;
            last_quadrature_packet <= 1'b0;
        end else begin
            start_fsms <= 1'b0;
            if (push && s00_axis_tlast) tlast_accepted <= 1'b1;
            case (state)
                SCH_IDLE: begin
                    if (s00_axis_tvalid) begin
                        state          <= SCH_PRIME;
                        tlast_accepted <= 1'b0;
                        underrun       <= 1'b0;
                    end
                end
                SCH_PRIME: begin
                    if ((occ_i == CW'(BURST_SIZE)) || tlast_accepted) state <= SCH_START;
                end
                SCH_START: begin
                    start_fsms             <= 1'b1;
                    inphase_packet         <= even_bits(head_i[W-1:0]);
                    quadrature_packet      <= odd_bits(head_q[W-1:0]);
                    last_inphase_packet    <= head_i[W];
                    last_quadrature_packet <= head_q[W];
                    state                  <= SCH_RUN;
                end
                SCH_RUN: begin
                    if (pop_i) begin
                        inphase_packet      <= even_bits(head_i[W-1:0]);
                        last_inphase_packet <= head_i[W];
                    end else if (inphase_receive_data && !last_inphase_packet) begin
                        underrun <= 1'b1;
                    end
                    if (pop_q) begin
                        quadrature_packet      <= odd_bits(head_q[W-1:0]);
                        last_quadrature_packet <= head_q[W];
                    end else if (quadrature_receive_data && !last_quadrature_packet) begin
                        underrun <= 1'b1;
                    end
                    if (last_inphase_packet && last_quadrature_packet) state <= SCH_WAIT_EOT;
                end
                SCH_WAIT_EOT: begin
                    if (end_of_transmission) state <= SCH_IDLE;
                end
                default: state <= SCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oqpsk_tx_scheduler.sv
// Directed bench for oqpsk_tx_scheduler: vector table of two-word transmissions plus corner sequences.
module tb_oqpsk_tx_scheduler;

    logic        aclk;
    logic        areset;
    logic [15:0] s00_axis_tdata;
    logic        s00_axis_tvalid;
    logic        s00_axis_tready;
    logic        s00_axis_tlast;
    logic        inphase_receive_data;
    logic        quadrature_receive_data;
    logic        end_of_transmission;
    logic        start_fsms;
    logic [7:0]  inphase_packet;
    logic [7:0]  quadrature_packet;
    logic        last_inphase_packet;
    logic        last_quadrature_packet;
    logic        busy;
    logic        underrun;

    int n_assert = 0;
    int n_fail   = 0;

    oqpsk_tx_scheduler dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .s00_axis_tdata          (s00_axis_tdata),
        .s00_axis_tvalid         (s00_axis_tvalid),
        .s00_axis_tready         (s00_axis_tready),
        .s00_axis_tlast          (s00_axis_tlast),
        .inphase_receive_data    (inphase_receive_data),
        .quadrature_receive_data (quadrature_receive_data),
        .end_of_transmission     (end_of_transmission),
        .start_fsms              (start_fsms),
        .inphase_packet          (inphase_packet),
        .quadrature_packet       (quadrature_packet),
        .last_inphase_packet     (last_inphase_packet),
        .last_quadrature_packet  (last_quadrature_packet),
        .busy                    (busy),
        .underrun                (underrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  i0;
        logic [7:0]  q0;
        logic [7:0]  i1;
        logic [7:0]  q1;
    } vec_t;

    vec_t tbl [5];

    // Six-word stream: word k carries the single bit pair k on both paths.
    logic [15:0] strm_w [6] = '{16'h0003, 16'h000C, 16'h0030, 16'h00C0, 16'h0300, 16'h0C00};
    logic [7:0]  strm_e [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        int n = 0;
        s00_axis_tdata  = d;
        s00_axis_tlast  = l;
        s00_axis_tvalid = 1'b1;
        while (!s00_axis_tready && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("send_word_tready_timeout", 32'(n >= 50), 32'd0);
        @(posedge aclk); #1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!start_fsms && n < 40) begin
            @(posedge aclk); #1;
            n++;
        end
        chk(nm, 32'(start_fsms), 32'd1);
    endtask

    task automatic issue_req(input logic ri, input logic rq);
        inphase_receive_data    = ri;
        quadrature_receive_data = rq;
        @(posedge aclk); #1;
        inphase_receive_data    = 1'b0;
        quadrature_receive_data = 1'b0;
    endtask

    task automatic end_tx(input string nm);
        @(posedge aclk); #1;
        chk({nm, "_busy_wait_eot"}, 32'(busy), 32'd1);
        end_of_transmission = 1'b1;
        @(posedge aclk); #1;
        end_of_transmission = 1'b0;
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_two(input vec_t v, input string nm);
        send_word(v.w0, 1'b0);
        send_word(v.w1, 1'b1);
        wait_start({nm, "_start"});
        chk({nm, "_i0"}, 32'(inphase_packet), 32'(v.i0));
        chk({nm, "_q0"}, 32'(quadrature_packet), 32'(v.q0));
        chk({nm, "_last0"}, 32'({last_inphase_packet, last_quadrature_packet}), 32'd0);
        issue_req(1'b1, 1'b1);
        chk({nm, "_start_one_cycle"}, 32'(start_fsms), 32'd0);
        chk({nm, "_i1"}, 32'(inphase_packet), 32'(v.i1));
        chk({nm, "_q1"}, 32'(quadrature_packet), 32'(v.q1));
        chk({nm, "_last1"}, 32'({last_inphase_packet, last_quadrature_packet}), 32'd3);
        end_tx(nm);
        chk({nm, "_i_hold"}, 32'(inphase_packet), 32'(v.i1));
    endtask

    initial begin
        logic [7:0] got_i [$];
        logic [7:0] got_q [$];
        logic       saw_low;

        tbl[0] = '{16'hAAAA, 16'h5555, 8'h00, 8'hFF, 8'hFF, 8'h00};
        tbl[1] = '{16'hFFFF, 16'h0000, 8'hFF, 8'hFF, 8'h00, 8'h00};
        tbl[2] = '{16'h0003, 16'hC000, 8'h01, 8'h01, 8'h80, 8'h80};
        tbl[3] = '{16'h000C, 16'h3000, 8'h02, 8'h02, 8'h40, 8'h40};
        tbl[4] = '{16'h0001, 16'h0002, 8'h01, 8'h00, 8'h00, 8'h01};

        areset = 1'b1;
        s00_axis_tdata = '0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast = 1'b0;
        inphase_receive_data = 1'b0;
        quadrature_receive_data = 1'b0;
        end_of_transmission = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tready", 32'(s00_axis_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start_fsms), 32'd0);
        chk("rst_packets", 32'({inphase_packet, quadrature_packet}), 32'd0);
        chk("rst_flags", 32'({last_inphase_packet, last_quadrature_packet, underrun}), 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        for (int t = 0; t < 5; t++) run_two(tbl[t], $sformatf("vec%0d", t));

        // Underrun with I drained early, end_of_transmission ignored in RUN.
        send_word(16'h0003, 1'b0);
        send_word(16'h000C, 1'b0);
        wait_start("ur_start");
        issue_req(1'b1, 1'b0);
        chk("ur_i_b", 32'(inphase_packet), 32'h02);
        chk("ur_flag_before", 32'(underrun), 32'd0);
        issue_req(1'b1, 1'b0);
        chk("ur_flag_set", 32'(underrun), 32'd1);
        chk("ur_i_held", 32'(inphase_packet), 32'h02);
        end_of_transmission = 1'b1;
        @(posedge aclk); #1;
        end_of_transmission = 1'b0;
        chk("eot_ignored_busy", 32'(busy), 32'd1);
        issue_req(1'b0, 1'b1);
        chk("ur_q_b", 32'(quadrature_packet), 32'h02);
        send_word(16'h0030, 1'b1);
        issue_req(1'b1, 1'b1);
        chk("ur_final_i", 32'(inphase_packet), 32'h04);
        chk("ur_final_q", 32'(quadrature_packet), 32'h04);
        chk("ur_final_last", 32'({last_inphase_packet, last_quadrature_packet}), 32'd3);
        chk("ur_sticky_run", 32'(underrun), 32'd1);
        end_tx("ur");
        chk("ur_sticky_idle", 32'(underrun), 32'd1);

        // Single tlast word primes immediately; also confirms underrun clears on IDLE->PRIME.
        s00_axis_tdata  = 16'h1234;
        s00_axis_tlast  = 1'b1;
        s00_axis_tvalid = 1'b1;
        @(posedge aclk); #1;
        chk("ur_cleared_prime", 32'(underrun), 32'd0);
        send_word(16'h1234, 1'b1);
        wait_start("single_start");
        chk("single_i", 32'(inphase_packet), 32'h46);
        chk("single_q", 32'(quadrature_packet), 32'h14);
        chk("single_last", 32'({last_inphase_packet, last_quadrature_packet}), 32'd3);
        end_tx("single");

        // Push, I pop and Q pop on the same edge.
        send_word(16'h0003, 1'b0);
        send_word(16'h000C, 1'b0);
        wait_start("sim_start");
        chk("sim_tready_pre", 32'(s00_axis_tready), 32'd1);
        s00_axis_tdata = 16'h0030;
        s00_axis_tlast = 1'b1;
        s00_axis_tvalid = 1'b1;
        issue_req(1'b1, 1'b1);
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast = 1'b0;
        chk("sim_i", 32'(inphase_packet), 32'h02);
        chk("sim_q", 32'(quadrature_packet), 32'h02);
        chk("sim_last", 32'({last_inphase_packet, last_quadrature_packet}), 32'd0);
        chk("sim_tready_post", 32'(s00_axis_tready), 32'd0);
        issue_req(1'b1, 1'b1);
        chk("sim_i2", 32'(inphase_packet), 32'h04);
        chk("sim_q2", 32'(quadrature_packet), 32'h04);
        chk("sim_last2", 32'({last_inphase_packet, last_quadrature_packet}), 32'd3);
        chk("sim_no_underrun", 32'(underrun), 32'd0);
        end_tx("sim");

        // Q requests trail I by two cycles while the producer keeps tvalid high.
        saw_low = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    int n = 0;
                    s00_axis_tdata  = strm_w[k];
                    s00_axis_tlast  = (k == 5);
                    s00_axis_tvalid = 1'b1;
                    while (!s00_axis_tready && n < 200) begin
                        @(posedge aclk); #1;
                        n++;
                    end
                    chk("lag_producer_timeout", 32'(n >= 200), 32'd0);
                    @(posedge aclk); #1;
                end
                s00_axis_tvalid = 1'b0;
                s00_axis_tlast  = 1'b0;
            end
            begin
                wait_start("lag_start");
                got_i.push_back(inphase_packet);
                got_q.push_back(quadrature_packet);
                for (int c = 0; c < 40; c++) begin
                    logic ri, rq;
                    if (last_inphase_packet && last_quadrature_packet) break;
                    ri = (c % 2 == 0) && !last_inphase_packet;
                    rq = (c >= 2) && (c % 2 == 0) && !last_quadrature_packet;
                    issue_req(ri, rq);
                    if (ri) got_i.push_back(inphase_packet);
                    if (rq) got_q.push_back(quadrature_packet);
                    if (s00_axis_tvalid && !s00_axis_tready) saw_low = 1'b1;
                end
            end
        join
        chk("lag_tready_low_seen", 32'(saw_low), 32'd1);
        chk("lag_underrun", 32'(underrun), 32'd0);
        chk("lag_count_i", 32'(got_i.size()), 32'd6);
        chk("lag_count_q", 32'(got_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("lag_i%0d", k), (got_i.size() > k) ? 32'(got_i[k]) : 32'hDEAD, 32'(strm_e[k]));
            chk($sformatf("lag_q%0d", k), (got_q.size() > k) ? 32'(got_q[k]) : 32'hDEAD, 32'(strm_e[k]));
        end
        end_tx("lag");

        // Asynchronous reset in RUN with an unread Q entry, then a clean transmission.
        send_word(16'h0003, 1'b0);
        send_word(16'h000C, 1'b0);
        wait_start("ar_start");
        issue_req(1'b1, 1'b0);
        issue_req(1'b1, 1'b0);
        chk("ar_underrun_pre", 32'(underrun), 32'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("ar_packets", 32'({inphase_packet, quadrature_packet}), 32'd0);
        chk("ar_flags", 32'({last_inphase_packet, last_quadrature_packet, underrun}), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_tready", 32'(s00_axis_tready), 32'd0);
        chk("ar_start_out", 32'(start_fsms), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        run_two(tbl[0], "ar_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
